// File: rtl/stopwatch_seven_segment_driver.sv
// Four-digit common-anode seven-segment scan driver for the stopwatch.
// Converts binary minutes/seconds to decimal digits and multiplexes them
// round-robin onto the display, one digit per DIGIT_PERIOD clocks.
// Anodes and segments are active-low and are registered together, so a
// digit value is never shown with the wrong anode.
// Optional build macro: MINUTES_LEADING_ZERO_BLANK_EN blanks a zero
// minutes-tens digit while keeping the scan timing unchanged.
module stopwatch_seven_segment_driver #(
  parameter int unsigned DIGIT_PERIOD = 50000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [5:0] minutes,
  input  logic [5:0] seconds,
  output logic [3:0] anode_signals,
  output logic [6:0] display_out
);

  localparam int unsigned CNT_W = (DIGIT_PERIOD > 1) ? $clog2(DIGIT_PERIOD) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIGIT_PERIOD - 1);

  logic [CNT_W-1:0] refresh_cnt;
  logic [1:0]       digit_idx;
  logic [3:0]       digit_val;
  logic [3:0]       anode_next;
  logic [6:0]       seg_next;

  function automatic logic [3:0] tens_of(input logic [5:0] value);
    return 4'(value / 6'd10);
  endfunction

  function automatic logic [3:0] ones_of(input logic [5:0] value);
    return 4'(value % 6'd10);
  endfunction

  // Active-low abcdefg pattern; non-decimal codes blank the digit.
  function automatic logic [6:0] seg_decode(input logic [3:0] digit);
    logic [6:0] seg;
    case (digit)
      4'd0:    seg = 7'b0000001;
      4'd1:    seg = 7'b1001111;
      4'd2:    seg = 7'b0010010;
      4'd3:    seg = 7'b0000110;
      4'd4:    seg = 7'b1001100;
      4'd5:    seg = 7'b0100100;
      4'd6:    seg = 7'b0100000;
      4'd7:    seg = 7'b0001111;
      4'd8:    seg = 7'b0000000;
      4'd9:    seg = 7'b0000100;
      default: seg = 7'b1111111;
    endcase
    return seg;
  endfunction

  // Refresh timer: count 0..DIGIT_PERIOD-1 and step the digit index on wrap.
  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values; blocking here would create order-dependent behaviour.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      refresh_cnt <= '0;
      digit_idx   <= 2'd0;
    end else if (refresh_cnt == CNT_MAX) begin
      refresh_cnt <= '0;
      digit_idx   <= digit_idx + 2'd1;
    end else begin
      refresh_cnt <= refresh_cnt + 1'b1;
    end
  end

  // Select the active digit's anode and value, then encode segments.
  // NOTE: every output gets a default first so no path leaves a value
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    anode_next = 4'b1111;
    digit_val  = 4'd0;
    case (digit_idx)
      2'd0: begin anode_next = 4'b0111; digit_val = tens_of(minutes); end
      2'd1: begin anode_next = 4'b1011; digit_val = ones_of(minutes); end
      2'd2: begin anode_next = 4'b1101; digit_val = tens_of(seconds); end
      2'd3: begin anode_next = 4'b1110; digit_val = ones_of(seconds); end
      default: begin anode_next = 4'b1111; digit_val = 4'd0; end
    endcase
    seg_next = seg_decode(digit_val);
`ifdef MINUTES_LEADING_ZERO_BLANK_EN
    if (digit_idx == 2'd0 && digit_val == 4'd0) seg_next = 7'b1111111;
`else
    // Minutes tens always shows, including a leading zero.
`endif
  end

  // Output registers: anode and segments load on the same edge from the
  // same index, refreshing segments every clock from the live inputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      anode_signals <= 4'b1111;
      display_out   <= 7'b1111111;
    end else begin
      anode_signals <= anode_next;
      display_out   <= seg_next;
    end
  end

endmodule

// File: tb/tb_stopwatch_seven_segment_driver.sv
// Directed self-checking bench for stopwatch_seven_segment_driver with a
// short DIGIT_PERIOD so every scan window is four clocks long.
// Honours MINUTES_LEADING_ZERO_BLANK_EN when the same macro is defined.
module tb_stopwatch_seven_segment_driver;

  localparam int P = 4;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] minutes = '0;
  logic [5:0] seconds = '0;
  logic [3:0] anode_signals;
  logic [6:0] display_out;

  int checks = 0;
  int errors = 0;
  int pos    = 0;   // edges since reset release

  stopwatch_seven_segment_driver #(.DIGIT_PERIOD(P)) dut (
    .clock         (clock),
    .reset         (reset),
    .minutes       (minutes),
    .seconds       (seconds),
    .anode_signals (anode_signals),
    .display_out   (display_out)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %b expected %b", tag, got, exp);
    end
  endtask

  function automatic logic [6:0] seg_tab(input int d);
    case (d)
      0: return 7'b0000001;
      1: return 7'b1001111;
      2: return 7'b0010010;
      3: return 7'b0000110;
      4: return 7'b1001100;
      5: return 7'b0100100;
      6: return 7'b0100000;
      7: return 7'b0001111;
      8: return 7'b0000000;
      9: return 7'b0000100;
      default: return 7'b1111111;
    endcase
  endfunction

  function automatic logic [3:0] anode_tab(input int idx);
    case (idx)
      0: return 4'b0111;
      1: return 4'b1011;
      2: return 4'b1101;
      default: return 4'b1110;
    endcase
  endfunction

  function automatic logic [6:0] disp_model(input int idx, input int m, input int s);
    case (idx)
      0: begin
`ifdef MINUTES_LEADING_ZERO_BLANK_EN
        if (m / 10 == 0) return 7'b1111111;
`endif
        return seg_tab(m / 10);
      end
      1: return seg_tab(m % 10);
      2: return seg_tab(s / 10);
      default: return seg_tab(s % 10);
    endcase
  endfunction

  // One clock, sampled 1 time unit after the edge, checked against the model.
  task automatic step();
    int idx;
    @(posedge clock);
    #1;
    pos++;
    idx = ((pos - 1) / P) % 4;
    check("scan_anode", 16'(anode_signals), 16'(anode_tab(idx)));
    check("scan_seg", 16'(display_out), 16'(disp_model(idx, int'(minutes), int'(seconds))));
  endtask

  task automatic run_frame();
    for (int i = 0; i < 4 * P; i++) step();
  endtask

  initial begin
    logic [6:0] exp_m0;

    // Reset held for three cycles: all segments and anodes off.
    minutes = 6'd0;
    seconds = 6'd37;
    #2 reset = 1'b0;
    #1;
    check("rst_async_anode", 16'(anode_signals), 16'h000f);
    check("rst_async_seg", 16'(display_out), 16'h007f);
    repeat (3) @(posedge clock);
    #1;
    check("rst_hold_anode", 16'(anode_signals), 16'h000f);
    check("rst_hold_seg", 16'(display_out), 16'h007f);

    // Release, then first edge selects minutes tens.
    reset = 1'b1;
    pos = 0;
    step();
    check("first_anode", 16'(anode_signals), 16'(4'b0111));
`ifdef MINUTES_LEADING_ZERO_BLANK_EN
    exp_m0 = 7'b1111111;
`else
    exp_m0 = 7'b0000001;
`endif
    check("m37_m_tens", 16'(display_out), 16'(exp_m0));
    repeat (P) step();
    check("m37_m_ones", 16'(display_out), 16'(7'b0000001));
    repeat (P) step();
    check("s37_tens_anode", 16'(anode_signals), 16'(4'b1101));
    check("s37_tens_seg", 16'(display_out), 16'(7'b0000110));
    repeat (P) step();
    check("s37_ones_anode", 16'(anode_signals), 16'(4'b1110));
    check("s37_ones_seg", 16'(display_out), 16'(7'b0001111));
    repeat (P - 1) step();   // finish frame; next edge begins index 0

    // Seconds sweep, one value per frame.
    for (int s = 0; s < 60; s++) begin
      seconds = 6'(s);
      run_frame();
    end

    // Minutes sweep with seconds = 0.
    seconds = 6'd0;
    for (int m = 0; m < 60; m++) begin
      minutes = 6'(m);
      run_frame();
    end

    // minutes = 48: explicit hand values.
    minutes = 6'd48;
    step();
    check("m48_tens", 16'(display_out), 16'(7'b1001100));
    repeat (P) step();
    check("m48_ones", 16'(display_out), 16'(7'b0000000));
    repeat (3 * P - 1) step();

    // Change seconds mid-window while 1110 is active.
    seconds = 6'd12;
    repeat (3 * P + 1) step();
    check("mid_before_anode", 16'(anode_signals), 16'(4'b1110));
    check("mid_before_seg", 16'(display_out), 16'(7'b0010010));
    seconds = 6'd45;
    #2;
    check("mid_no_edge_seg", 16'(display_out), 16'(7'b0010010));
    step();
    check("mid_after_anode", 16'(anode_signals), 16'(4'b1110));
    check("mid_after_seg", 16'(display_out), 16'(7'b0100100));
    repeat (P - 2) step();

    // Reset asserted during 1101, between clock edges.
    repeat (2 * P + 1) step();
    check("pre_rst_anode", 16'(anode_signals), 16'(4'b1101));
    #2 reset = 1'b0;
    #1;
    check("mid_rst_anode", 16'(anode_signals), 16'h000f);
    check("mid_rst_seg", 16'(display_out), 16'h007f);
    @(posedge clock);
    #1;
    check("mid_rst_hold", 16'({anode_signals, display_out}), 16'h07ff);
    reset = 1'b1;
    pos = 0;
    step();
    check("restart_anode", 16'(anode_signals), 16'(4'b0111));
    repeat (4 * P - 1) step();

    // minutes = 5: leading zero blanked only when the feature is built in.
    minutes = 6'd5;
    seconds = 6'd0;
    step();
    check("m5_tens", 16'(display_out), 16'(exp_m0));
    repeat (P) step();
    check("m5_ones_anode", 16'(anode_signals), 16'(4'b1011));
    check("m5_ones_seg", 16'(display_out), 16'(7'b0100100));
    repeat (3 * P - 1) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/stopwatch_seven_segment_driver.md
Name: stopwatch_seven_segment_driver

Overview:
Time-multiplexed driver for a 4-digit common-anode seven-segment display in the stopwatch datapath. Takes binary minutes and seconds from the stopwatch counter. Converts each value to two decimal digits and scans the four digits round-robin. Drives active-low anode enables and active-low segment lines.

Parameters:
DIGIT_PERIOD, 50000, clock cycles each digit stays enabled before advancing; 1 ms at 50 MHz, 4 ms full frame; legal range 2..2^20.

Ports:
clock  input  1  system clock, 50 MHz nominal; all state on rising edge
reset  input  1  asynchronous, active-low reset (asserted when 0)
minutes  input  6  binary minutes, 0..63 displayed (stopwatch uses 0..59)
seconds  input  6  binary seconds, 0..63 displayed (stopwatch uses 0..59)
anode_signals  output  4  active-low digit enables; bit3 = minutes tens, bit2 = minutes ones, bit1 = seconds tens, bit0 = seconds ones
display_out  output  7  active-low segments; bit6..bit0 = a,b,c,d,e,f,g

Behaviour:
- Reset (reset=0, asynchronous): refresh counter=0, digit index=0, anode_signals=4'b1111 (all off), display_out=7'b1111111 (all off).
- Refresh counter counts 0..DIGIT_PERIOD-1 and wraps. On wrap, digit index advances 0->1->2->3->0.
- Index 0: anodes 0111, minutes/10. Index 1: anodes 1011, minutes%10. Index 2: anodes 1101, seconds/10. Index 3: anodes 1110, seconds%10.
- Exactly one anode bit is low at any time after the first clock edge following reset release. No other anode patterns occur.
- anode_signals and display_out are both registered and update on the same edge. They never show a digit value paired with the wrong anode.
- display_out is recomputed every clock from the current inputs for the active digit. An input change is reflected one clock later, without waiting for the next digit advance.
- Binary-to-decimal: tens = value/10, ones = value%10. For inputs 0..63 this gives tens 0..6. Combinational divide or a small lookup is acceptable.
- Segment code (abcdefg, active-low):
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100
  - 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100
  - Any other code gives 1111111.
- Inputs are assumed synchronous to clock. No input registering or debouncing.
- Reset asserted mid-scan: outputs go to the reset values immediately. After release, scanning restarts at index 0.

Optional Feature:
MINUTES_LEADING_ZERO_BLANK_EN
- Defined: when the minutes tens digit is 0, display_out=1111111 during index 0. anode_signals still follows the normal scan pattern, so timing is unchanged.
- Undefined: minutes tens always displays, including 0 as 0000001.

Test Plan:
- Reset behaviour, DIGIT_PERIOD=4: hold reset=0 for 3 cycles -> anodes 1111, display_out 1111111. Release -> next edge gives anodes 0111; anodes then change every 4 cycles through 1011, 1101, 1110, 0111.
- seconds=37, minutes=0 -> during 1101 display_out=0000110 (3); during 1110 display_out=0001111 (7); during 0111 and 1011 display_out=0000001 (macro undefined).
- Sweep seconds 0..59, one value per frame -> every 1101/1110 window shows the tens/ones codes from the table; no mismatch.
- Sweep minutes 0..59 with seconds=0 -> 0111/1011 windows show minutes/10 and minutes%10; e.g. minutes=48 gives 1001100 then 0000000.
- Change seconds 12->45 mid-window while 1110 is active -> display_out goes 0010010 -> 0100100 one clock later; anodes unchanged.
- Assert reset mid-frame during 1101 -> outputs go 1111/1111111 without a clock edge; after release the scan restarts at 0111.
- MINUTES_LEADING_ZERO_BLANK_EN defined, minutes=5 -> during 0111 display_out=1111111; during 1011 display_out=0100100.
